vga_line_buffer: RTL
====================

// Module: vga_line_buffer
// PURPOSE
//  Ping-pong line buffer that sits directly upstream of the VGA display stage.
//  A producer (memory controller / accelerator) streams one scan line of pixels into the fill bank.
//  The display stage reads the other bank, indexed by hcount[10:1].
//  Banks swap at end of each line; missed deadlines repeat the previous line and are flagged.
// PARAMETERS
//  PIX_W     24    pixel width, {R,G,B} 8 bits each
//  LINE_PIX  640   pixels per displayed line (bank depth)
//  AW        10    bank address width, 2**AW >= LINE_PIX
//  HTOTAL    1600  clk cycles per line; swap point is hcount == HTOTAL-1
//  VACTIVE   480   active lines; underflow is only checked while vcount < VACTIVE
// PORTS
//  clk            in   1      system clock (50 MHz)
//  reset          in   1      asynchronous, active-high reset
//  in_valid       in   1      producer pixel valid
//  in_ready       out  1      buffer can accept a pixel this cycle
//  in_data        in   PIX_W  pixel {R,G,B}
//  in_last        in   1      marks last pixel of a (possibly short) line
//  hcount         in   11     from vga_counters; hcount[10:1] is pixel column
//  vcount         in   10     from vga_counters
//  pix_out        out  PIX_W  registered display pixel
//  line_req       out  1      1-cycle pulse: fill bank free, send next line
//  underflow      out  1      sticky: swap point reached with line incomplete
//  clr_underflow  in   1      synchronous clear of underflow (and counter)
//  underflow_cnt  out  16     only with LB_UNDERFLOW_CNT_EN
// BEHAVIOUR
//  Reset values: in_ready=1, pix_out=0, line_req=0, underflow=0, underflow_cnt=0.
//  Reset internal state: state=FILL, wr_ptr=0, disp_sel=0, disp_valid=0, disp_len=0.
//  Reset asserted mid-line aborts the fill; the partial line is discarded.
//  FSM: FILL, FULL.
//   FILL: in_ready=1. On handshake, write bank[~disp_sel][wr_ptr] and increment wr_ptr.
//    If in_last or wr_ptr==LINE_PIX-1: fill_len<=wr_ptr+1 and go to FULL.
//   FULL: in_ready=0. Waits for the swap point.
//  Swap point is hcount==HTOTAL-1. Line is complete if state==FULL, or if the completing
//  handshake occurs in that same cycle (that handshake counts).
//   Line complete: disp_sel toggles, disp_len<=fill_len, disp_valid<=1, wr_ptr<=0,
//    state<=FILL, line_req pulses the next cycle.
//   Line incomplete, vcount<VACTIVE: no swap, underflow<=1, displayed line repeats,
//    fill continues uninterrupted.
//   Line incomplete, vcount>=VACTIVE: no swap, no flag.
//  Read path, 1-cycle latency: pix_out <= bank[disp_sel][hcount[10:1]].
//   pix_out is 0 if !disp_valid, hcount[10:1]>=disp_len, or hcount[10:1]>=LINE_PIX.
//   Because each pixel lasts 2 clks, the display stage samples it at the 2nd clk.
//  clr_underflow together with a new underflow event in the same cycle: set wins.
//  No handshake is lost: data is only written when in_valid&&in_ready.
// CONFIGURATION
//  LB_UNDERFLOW_CNT_EN defined:
//   underflow_cnt counts every flagged underflow event.
//   Saturates at 16'hFFFF; cleared with underflow.
//  LB_UNDERFLOW_CNT_EN undefined:
//   port and counter are absent; only the sticky flag exists.
// TESTING
//  Reset, then 640 px in_data=i, never in_last, before 1st swap
//   -> line_req 1 clk after swap; pix_out at col c = c; in_ready=0 from px 640 to swap.
//  Short line, 100 px, in_last on px 99
//   -> cols 0..99 = data; cols 100..639 = 0; hcount>=1280 -> 0.
//  Only 300 px delivered by swap, vcount=10
//   -> underflow=1, previous line repeated;
//   remaining px accepted, swap at next line end.
//  Last handshake in the exact cycle hcount==1599
//   -> swap occurs, no underflow, line_req next cycle.
//  Incomplete line at swap with vcount=500 -> no underflow.
//   clr_underflow with simultaneous event -> underflow stays 1.
//  Async reset pulse mid-fill (wr_ptr=200)
//   -> all outputs reset immediately, pix_out=0 until next full line swaps.
//   With LB_UNDERFLOW_CNT_EN: 3 underflows -> cnt=3.

Source files
------------

// File: rtl/vga_line_buffer.sv
// Ping-pong scan-line buffer between a pixel producer and the VGA display stage.
// Optional saturating underflow event counter enabled by LB_UNDERFLOW_CNT_EN.

module vga_line_buffer #(
    parameter int unsigned PIX_W    = 24,
    parameter int unsigned LINE_PIX = 640,
    parameter int unsigned AW       = 10,
    parameter int unsigned HTOTAL   = 1600,
    parameter int unsigned VACTIVE  = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_last,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    output logic [PIX_W-1:0] pix_out,
    output logic             line_req,
    output logic             underflow,
    input  logic             clr_underflow
`ifdef LB_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]      underflow_cnt
`endif
);

    localparam int unsigned LEN_W = AW + 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]   fill_len_q, fill_len_d;
    logic [LEN_W-1:0]   disp_len_q, disp_len_d;
    logic               disp_sel_q, disp_sel_d;
    logic               disp_valid_q, disp_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [PIX_W-1:0]   pix_out_q, pix_out_d;
    logic               line_req_q, line_req_d;
    logic               underflow_q, underflow_d;

    logic [PIX_W-1:0]   bank0_mem [LINE_PIX];
    logic [PIX_W-1:0]   bank1_mem [LINE_PIX];

    logic               hs;
    logic               fill_done;
    logic               swap_pt;
    logic               line_done;
    logic               uf_event;
    logic [LEN_W-1:0]   new_len;
    logic [AW-1:0]      col;
    logic               col_ok;
    logic [AW-1:0]      rd_addr;
    logic [PIX_W-1:0]   rd_word;

    assign hs        = in_valid && (state_q == ST_FILL);
    assign fill_done = hs && (in_last || (wr_ptr_q == AW'(LINE_PIX - 1)));
    assign new_len   = LEN_W'(wr_ptr_q) + LEN_W'(1);
    assign swap_pt   = (hcount == 11'(HTOTAL - 1));
    // A handshake that completes the line on the swap cycle still counts.
    assign line_done = (state_q == ST_FULL) || fill_done;
    assign uf_event  = swap_pt && !line_done && (vcount < 10'(VACTIVE));

    // Each displayed pixel spans two clocks, so the column is hcount/2.
    assign col     = hcount[10:1];
    assign col_ok  = disp_valid_q && (LEN_W'(col) < disp_len_q) && (LEN_W'(col) < LEN_W'(LINE_PIX));
    assign rd_addr = col_ok ? col : '0;
    assign rd_word = disp_sel_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];

    // Producer writes always land in the bank not being displayed.
    always_ff @(posedge clk) begin
        if (hs) begin
            if (disp_sel_q) begin
                bank0_mem[wr_ptr_q] <= in_data;
            end else begin
                bank1_mem[wr_ptr_q] <= in_data;
            end
        end
    end

    // Fill FSM, bank swap and sticky underflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_len_d   = fill_len_q;
        disp_len_d   = disp_len_q;
        disp_sel_d   = disp_sel_q;
        disp_valid_d = disp_valid_q;
        line_req_d   = 1'b0;
        underflow_d  = underflow_q;
        pix_out_d    = col_ok ? rd_word : '0;

        case (state_q)
            ST_FILL: begin
                if (hs) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
                if (fill_done) begin
                    fill_len_d = new_len;
                    state_d    = ST_FULL;
                end
            end
            ST_FULL: begin
                state_d = ST_FULL;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (swap_pt && line_done) begin
            disp_sel_d   = ~disp_sel_q;
            disp_len_d   = fill_done ? new_len : fill_len_q;
            disp_valid_d = 1'b1;
            wr_ptr_d     = '0;
            state_d      = ST_FILL;
            line_req_d   = 1'b1;
        end

        if (uf_event) begin
            underflow_d = 1'b1;
        end else if (clr_underflow) begin
            underflow_d = 1'b0;
        end

        in_ready_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FILL;
            wr_ptr_q     <= '0;
            fill_len_q   <= '0;
            disp_len_q   <= '0;
            disp_sel_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            pix_out_q    <= '0;
            line_req_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_len_q   <= fill_len_d;
            disp_len_q   <= disp_len_d;
            disp_sel_q   <= disp_sel_d;
            disp_valid_q <= disp_valid_d;
            in_ready_q   <= in_ready_d;
            pix_out_q    <= pix_out_d;
            line_req_q   <= line_req_d;
            underflow_q  <= underflow_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign pix_out   = pix_out_q;
    assign line_req  = line_req_q;
    assign underflow = underflow_q;

`ifdef LB_UNDERFLOW_CNT_EN
    logic [CNT_W-1:0] ucnt_q, ucnt_d;

    // Saturating event count; a new event beats a same-cycle clear.
    always_comb begin
        ucnt_d = ucnt_q;
        if (uf_event) begin
            if (ucnt_q != {CNT_W{1'b1}}) begin
                ucnt_d = ucnt_q + CNT_W'(1);
            end
        end else if (clr_underflow) begin
            ucnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule
